// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, sequences fixed-latency reads of
// instruction memory and hands each instruction to decode over valid/ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          IMEM_BYTES = 1024,
    parameter int          MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_pc,
    output logic        imem_req,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_fault,
    output logic [15:0] fetch_count
);

    localparam int          CNT_W   = $clog2(MEM_LAT + 1);
    localparam logic [31:0] LAST_PC = RESET_PC + 32'(IMEM_BYTES) - 32'd4;
    localparam logic [9:0]  BASE_LO = RESET_PC[9:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_pc;
    logic [CNT_W-1:0]   r_wait;

    logic               w_active;
    logic               w_legal;
    logic               w_redir_ok;
    logic               w_redir_bad;
    logic               w_fire;
    logic               w_capture;
    logic [31:0]        w_pc_seq;

    assign w_active    = (r_state != S_FAULT);
    assign w_legal     = (redirect_target >= RESET_PC) && (redirect_target <= LAST_PC) &&
                         (redirect_target[1:0] == 2'b00);
    assign w_redir_ok  = redirect_valid && w_active && w_legal;
    assign w_redir_bad = redirect_valid && w_active && !w_legal;
    assign w_fire      = if_valid && id_ready;
    // A redirect in the data-return cycle drops the response instead of capturing it.
    assign w_capture   = (r_state == S_WAIT) && (r_wait == CNT_W'(1)) && !redirect_valid;
    assign w_pc_seq    = (r_pc == LAST_PC) ? RESET_PC : r_pc + 32'd4;
    assign imem_addr   = r_pc[9:0] - BASE_LO;

    always_ff @(posedge clk or posedge rst_pc) begin
        if (rst_pc) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        imem_req    = 1'b0;
        if_valid    = 1'b0;
        fetch_fault = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_ISSUE;
            S_ISSUE: begin
                imem_req = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == CNT_W'(1)) w_next = S_HOLD;
            end
            S_HOLD: begin
                if_valid = !redirect_valid;
                if (id_ready && !redirect_valid) w_next = S_ISSUE;
            end
            S_FAULT: fetch_fault = 1'b1;
            default: w_next = S_IDLE;
        endcase
        if (w_redir_ok) begin
            w_next = S_ISSUE;
        end else if (w_redir_bad) begin
            w_next = S_FAULT;
        end
    end

    always_ff @(posedge clk or posedge rst_pc) begin
        if (rst_pc) begin
            r_pc        <= RESET_PC;
            r_wait      <= '0;
            if_instr    <= 32'd0;
            if_pc       <= RESET_PC;
            fetch_count <= 16'd0;
        end else begin
            if (w_redir_ok) begin
                r_pc <= redirect_target;
            end else if (w_fire) begin
                r_pc <= w_pc_seq;
            end
            if (w_fire) fetch_count <= fetch_count + 16'd1;
            if (r_state == S_ISSUE) begin
                r_wait <= CNT_W'(MEM_LAT);
            end else if (r_state == S_WAIT && r_wait != '0) begin
                r_wait <= r_wait - CNT_W'(1);
            end
            if (w_capture) begin
                if_instr <= imem_rdata;
                if_pc    <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each fed by a fixed-latency pipelined memory model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] q1[$];
    logic [31:0] q3[$];

    logic        rst1 = 1'b1, rdy1 = 1'b0, rv1 = 1'b0;
    logic [31:0] rt1 = 32'd0;
    logic        req1, v1, fault1;
    logic [9:0]  addr1;
    logic [31:0] rdata1, instr1, pc1;
    logic [15:0] cnt1;

    logic        rst3 = 1'b1, rdy3 = 1'b0, rv3 = 1'b0;
    logic [31:0] rt3 = 32'd0;
    logic        req3, v3, fault3;
    logic [9:0]  addr3;
    logic [31:0] rdata3, instr3, pc3;
    logic [15:0] cnt3;

    fetch_sequencer #(.RESET_PC(32'h0000_3000), .IMEM_BYTES(1024), .MEM_LAT(1)) u1 (
        .clk(clk), .rst_pc(rst1), .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .if_valid(v1), .id_ready(rdy1), .if_instr(instr1), .if_pc(pc1),
        .redirect_valid(rv1), .redirect_target(rt1), .fetch_fault(fault1), .fetch_count(cnt1));

    fetch_sequencer #(.RESET_PC(32'h0000_3000), .IMEM_BYTES(1024), .MEM_LAT(3)) u3 (
        .clk(clk), .rst_pc(rst3), .imem_req(req3), .imem_addr(addr3), .imem_rdata(rdata3),
        .if_valid(v3), .id_ready(rdy3), .if_instr(instr3), .if_pc(pc3),
        .redirect_valid(rv3), .redirect_target(rt3), .fetch_fault(fault3), .fetch_count(cnt3));

    function automatic logic [31:0] instr_of(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a};
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - 32'h0000_3000;
        return instr_of(off[9:0]);
    endfunction

    // Memory models: data for a request in cycle t is visible in cycle t+L.
    logic       m1_vld = 1'b0;
    logic [9:0] m1_addr = 10'd0;
    always @(posedge clk) begin
        m1_vld  <= req1;
        m1_addr <= addr1;
    end
    assign rdata1 = m1_vld ? instr_of(m1_addr) : 32'hDEAD_BEEF;

    logic       m3_vld[3] = '{1'b0, 1'b0, 1'b0};
    logic [9:0] m3_addr[3] = '{10'd0, 10'd0, 10'd0};
    always @(posedge clk) begin
        m3_vld[0]  <= req3;
        m3_addr[0] <= addr3;
        for (int i = 1; i < 3; i++) begin
            m3_vld[i]  <= m3_vld[i-1];
            m3_addr[i] <= m3_addr[i-1];
        end
    end
    assign rdata3 = m3_vld[2] ? instr_of(m3_addr[2]) : 32'hDEAD_BEEF;

    // Scoreboard: every accepted instruction must match the next expected PC.
    always @(negedge clk) begin
        if (v1 && rdy1) begin
            logic [31:0] e;
            n_cmp++;
            if (q1.size() == 0) begin
                n_fail++; $display("FAIL hs1_unexpected got pc=%h required no handshake", pc1);
            end else begin
                e = q1.pop_front();
                if (pc1 !== e || instr1 !== exp_instr(e)) begin
                    n_fail++; $display("FAIL hs1 got pc=%h instr=%h required pc=%h instr=%h", pc1, instr1, e, exp_instr(e));
                end
            end
        end
        if (v3 && rdy3) begin
            logic [31:0] e;
            n_cmp++;
            if (q3.size() == 0) begin
                n_fail++; $display("FAIL hs3_unexpected got pc=%h required no handshake", pc3);
            end else begin
                e = q3.pop_front();
                if (pc3 !== e || instr3 !== exp_instr(e)) begin
                    n_fail++; $display("FAIL hs3 got pc=%h instr=%h required pc=%h instr=%h", pc3, instr3, e, exp_instr(e));
                end
            end
        end
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_valid(input bit sel3, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel3 ? v3 : v1) && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if ((sel3 ? v3 : v1) !== 1'b1) begin
            n_fail++; $display("FAIL wait_valid%0d got timeout after %0d cycles required if_valid", sel3 ? 3 : 1, bound);
        end
    endtask

    task automatic test_reset();
        smp();
        n_cmp++; if (req1 !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0h required 0", req1); end
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h required 0", v1); end
        n_cmp++; if (fault1 !== 1'b0) begin n_fail++; $display("FAIL rst_fault got %0h required 0", fault1); end
        n_cmp++; if (instr1 !== 32'd0) begin n_fail++; $display("FAIL rst_instr got %h required 0", instr1); end
        n_cmp++; if (pc1 !== 32'h3000) begin n_fail++; $display("FAIL rst_pc got %h required 3000", pc1); end
        n_cmp++; if (cnt1 !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d required 0", cnt1); end
        n_cmp++; if (addr1 !== 10'd0) begin n_fail++; $display("FAIL rst_addr got %h required 0", addr1); end
    endtask

    task automatic test_steady();
        drv(); rst1 = 1'b0; rdy1 = 1'b1; q1.push_back(32'h3000);
        smp();
        n_cmp++; if (req1 !== 1'b0) begin n_fail++; $display("FAIL idle_req got %0h required 0", req1); end
        drv(); smp();
        n_cmp++; if (req1 !== 1'b1 || addr1 !== 10'h000) begin n_fail++; $display("FAIL issue0 got req=%0h addr=%h required 1/000", req1, addr1); end
        drv(); smp();
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL wait0_valid got %0h required 0", v1); end
        drv(); smp();
        n_cmp++; if (v1 !== 1'b1 || pc1 !== 32'h3000) begin n_fail++; $display("FAIL hold0 got v=%0h pc=%h required 1/3000", v1, pc1); end
        drv(); rdy1 = 1'b0; smp();
        n_cmp++; if (req1 !== 1'b1 || addr1 !== 10'h004) begin n_fail++; $display("FAIL issue1 got req=%0h addr=%h required 1/004", req1, addr1); end
        n_cmp++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL count1 got %0d required 1", cnt1); end
    endtask

    task automatic test_backpressure();
        wait_valid(1'b0, 8);
        n_cmp++; if (pc1 !== 32'h3004 || instr1 !== exp_instr(32'h3004)) begin n_fail++; $display("FAIL bp_first got pc=%h instr=%h required 3004", pc1, instr1); end
        for (int i = 0; i < 5; i++) begin
            drv(); smp();
            n_cmp++;
            if (v1 !== 1'b1 || req1 !== 1'b0 || pc1 !== 32'h3004 || instr1 !== exp_instr(32'h3004)) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%0h req=%0h pc=%h instr=%h required 1/0/3004", i, v1, req1, pc1, instr1);
            end
        end
        drv(); q1.push_back(32'h3004); rdy1 = 1'b1; smp();
        n_cmp++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL bp_accept got v=%0h required 1", v1); end
        drv(); rdy1 = 1'b0; smp();
        n_cmp++; if (req1 !== 1'b1 || addr1 !== 10'h008 || cnt1 !== 16'd2) begin n_fail++; $display("FAIL bp_next got req=%0h addr=%h cnt=%0d required 1/008/2", req1, addr1, cnt1); end
    endtask

    task automatic test_redirect_wait();
        drv(); rv1 = 1'b1; rt1 = 32'h3100; smp();
        n_cmp++; if (v1 !== 1'b0 || req1 !== 1'b0) begin n_fail++; $display("FAIL rw_wait got v=%0h req=%0h required 0/0", v1, req1); end
        drv(); rv1 = 1'b0; smp();
        n_cmp++; if (req1 !== 1'b1 || addr1 !== 10'h100) begin n_fail++; $display("FAIL rw_issue got req=%0h addr=%h required 1/100", req1, addr1); end
        n_cmp++; if (cnt1 !== 16'd2 || pc1 !== 32'h3004) begin n_fail++; $display("FAIL rw_dropped got cnt=%0d if_pc=%h required 2/3004", cnt1, pc1); end
        wait_valid(1'b0, 8);
        n_cmp++; if (pc1 !== 32'h3100 || instr1 !== exp_instr(32'h3100)) begin n_fail++; $display("FAIL rw_present got pc=%h instr=%h required 3100", pc1, instr1); end
    endtask

    task automatic test_redirect_ready();
        drv(); rdy1 = 1'b1; rv1 = 1'b1; rt1 = 32'h3200; smp();
        n_cmp++; if (v1 !== 1'b0 || cnt1 !== 16'd2) begin n_fail++; $display("FAIL rr_mask got v=%0h cnt=%0d required 0/2", v1, cnt1); end
        drv(); rdy1 = 1'b0; rv1 = 1'b0; smp();
        n_cmp++; if (req1 !== 1'b1 || addr1 !== 10'h200 || cnt1 !== 16'd2) begin n_fail++; $display("FAIL rr_issue got req=%0h addr=%h cnt=%0d required 1/200/2", req1, addr1, cnt1); end
        wait_valid(1'b0, 8);
        n_cmp++; if (pc1 !== 32'h3200) begin n_fail++; $display("FAIL rr_present got pc=%h required 3200", pc1); end
        drv(); q1.push_back(32'h3200); rdy1 = 1'b1; smp();
        drv(); rdy1 = 1'b0; smp();
        n_cmp++; if (addr1 !== 10'h204 || cnt1 !== 16'd3) begin n_fail++; $display("FAIL rr_next got addr=%h cnt=%0d required 204/3", addr1, cnt1); end
    endtask

    task automatic test_wrap_fault();
        drv(); rv1 = 1'b1; rt1 = 32'h33FC; smp();
        drv(); rv1 = 1'b0; smp();
        n_cmp++; if (req1 !== 1'b1 || addr1 !== 10'h3FC) begin n_fail++; $display("FAIL wrap_issue got req=%0h addr=%h required 1/3fc", req1, addr1); end
        wait_valid(1'b0, 8);
        n_cmp++; if (pc1 !== 32'h33FC || instr1 !== exp_instr(32'h33FC)) begin n_fail++; $display("FAIL wrap_present got pc=%h instr=%h required 33fc", pc1, instr1); end
        drv(); q1.push_back(32'h33FC); rdy1 = 1'b1; smp();
        drv(); rdy1 = 1'b0; smp();
        n_cmp++; if (req1 !== 1'b1 || addr1 !== 10'h000 || cnt1 !== 16'd4 || fault1 !== 1'b0) begin
            n_fail++; $display("FAIL wrap_next got req=%0h addr=%h cnt=%0d fault=%0h required 1/000/4/0", req1, addr1, cnt1, fault1);
        end
        wait_valid(1'b0, 8);
        n_cmp++; if (pc1 !== 32'h3000 || instr1 !== exp_instr(32'h3000)) begin n_fail++; $display("FAIL wrap_present0 got pc=%h required 3000", pc1); end
        drv(); rv1 = 1'b1; rt1 = 32'h3002; smp();
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL fault_mask got v=%0h required 0", v1); end
        drv(); rv1 = 1'b0; smp();
        n_cmp++; if (fault1 !== 1'b1 || req1 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL fault_unaligned got fault=%0h req=%0h v=%0h required 1/0/0", fault1, req1, v1); end
        for (int i = 0; i < 3; i++) begin
            drv(); rv1 = (i == 0); rt1 = 32'h3100; rdy1 = 1'b1; smp();
            n_cmp++; if (fault1 !== 1'b1 || req1 !== 1'b0 || v1 !== 1'b0) begin n_fail++; $display("FAIL fault_sticky%0d got fault=%0h req=%0h v=%0h required 1/0/0", i, fault1, req1, v1); end
        end
        drv(); rv1 = 1'b0; rdy1 = 1'b0; #2; rst1 = 1'b1; #1;
        n_cmp++; if (fault1 !== 1'b0 || cnt1 !== 16'd0) begin n_fail++; $display("FAIL fault_clear got fault=%0h cnt=%0d required 0/0", fault1, cnt1); end
        smp(); drv(); rst1 = 1'b0;
        wait_valid(1'b0, 8);
        n_cmp++; if (pc1 !== 32'h3000) begin n_fail++; $display("FAIL refetch got pc=%h required 3000", pc1); end
        drv(); rv1 = 1'b1; rt1 = 32'h3400; smp();
        drv(); rv1 = 1'b0; smp();
        n_cmp++; if (fault1 !== 1'b1 || req1 !== 1'b0) begin n_fail++; $display("FAIL fault_range got fault=%0h req=%0h required 1/0", fault1, req1); end
    endtask

    task automatic test_midop_reset();
        drv(); rst3 = 1'b0; rdy3 = 1'b1; q3.push_back(32'h3000); smp();
        n_cmp++; if (req3 !== 1'b0) begin n_fail++; $display("FAIL l3_idle got req=%0h required 0", req3); end
        drv(); smp();
        n_cmp++; if (req3 !== 1'b1 || addr3 !== 10'h000) begin n_fail++; $display("FAIL l3_issue got req=%0h addr=%h required 1/000", req3, addr3); end
        for (int k = 1; k <= 3; k++) begin
            drv(); smp();
            n_cmp++; if (v3 !== 1'b0) begin n_fail++; $display("FAIL l3_wait%0d got v=%0h required 0", k, v3); end
        end
        drv(); smp();
        n_cmp++; if (v3 !== 1'b1 || pc3 !== 32'h3000) begin n_fail++; $display("FAIL l3_latency got v=%0h pc=%h required 1/3000", v3, pc3); end
        drv(); smp();
        n_cmp++; if (req3 !== 1'b1 || addr3 !== 10'h004 || cnt3 !== 16'd1) begin n_fail++; $display("FAIL l3_next got req=%0h addr=%h cnt=%0d required 1/004/1", req3, addr3, cnt3); end
        drv(); #2; rst3 = 1'b1; #1;
        n_cmp++; if (req3 !== 1'b0 || v3 !== 1'b0 || fault3 !== 1'b0 || addr3 !== 10'h000) begin
            n_fail++; $display("FAIL l3_rst_ctl got req=%0h v=%0h fault=%0h addr=%h required 0/0/0/000", req3, v3, fault3, addr3);
        end
        n_cmp++; if (instr3 !== 32'd0 || pc3 !== 32'h3000 || cnt3 !== 16'd0) begin
            n_fail++; $display("FAIL l3_rst_data got instr=%h pc=%h cnt=%0d required 0/3000/0", instr3, pc3, cnt3);
        end
        smp(); drv(); smp(); drv(); rst3 = 1'b0; q3.push_back(32'h3000); smp();
        n_cmp++; if (req3 !== 1'b0) begin n_fail++; $display("FAIL l3_reidle got req=%0h required 0", req3); end
        drv(); smp();
        n_cmp++; if (req3 !== 1'b1 || addr3 !== 10'h000) begin n_fail++; $display("FAIL l3_restart got req=%0h addr=%h required 1/000", req3, addr3); end
        wait_valid(1'b1, 8);
        n_cmp++; if (pc3 !== 32'h3000 || instr3 !== exp_instr(32'h3000)) begin n_fail++; $display("FAIL l3_present got pc=%h instr=%h required 3000", pc3, instr3); end
        drv(); rdy3 = 1'b0; smp();
        n_cmp++; if (cnt3 !== 16'd1 || addr3 !== 10'h004) begin n_fail++; $display("FAIL l3_count got cnt=%0d addr=%h required 1/004", cnt3, addr3); end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ready();
        test_wrap_fault();
        test_midop_reset();
        drv(); smp();
        n_cmp++; if (q1.size() != 0) begin n_fail++; $display("FAIL sb1_drain got %0d pending required 0", q1.size()); end
        n_cmp++; if (q3.size() != 0) begin n_fail++; $display("FAIL sb3_drain got %0d pending required 0", q3.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
